// File: rtl/cache_wr_ctl.sv
// Write-port controller for the cache data array: merges buffered byte-enabled
// stores with critical-word-first line reloads and flags reads that may see stale data.
module cache_wr_ctl #(
  parameter int unsigned ADR_W      = 10,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SQ_DEPTH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_val,
  output logic             st_rdy,
  input  logic [ADR_W-1:0] st_adr,
  input  logic [3:0]       st_be,
  input  logic [31:0]      st_dat,
  input  logic             rld_start,
  input  logic [ADR_W-1:0] rld_adr,
  output logic             rld_busy,
  output logic             rld_rdy,
  input  logic             rld_val,
  input  logic [31:0]      rld_dat,
  output logic             rld_done,
  output logic             sq_empty,
  input  logic [ADR_W-1:0] rd_adr,
  output logic             rd_hazard,
  output logic [3:0]       wr_en,
  output logic [ADR_W-1:0] wr_adr,
  output logic [31:0]      wr_dat
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned PTR_W = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(SQ_DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SQ_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SQ_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [OFF_W-1:0] OFF_ONE  = OFF_W'(1);
  localparam logic [OFF_W:0]   BEAT_ONE = (OFF_W+1)'(1);
  localparam logic [OFF_W:0]   BEAT_END = (OFF_W+1)'(LINE_WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_RLD   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADR_W-1:0]    sq_adr_q [SQ_DEPTH];
  logic [3:0]          sq_be_q  [SQ_DEPTH];
  logic [31:0]         sq_dat_q [SQ_DEPTH];
  logic [SQ_DEPTH-1:0] sq_vld_q, sq_vld_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [ADR_W-1:0] base_q, base_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [OFF_W:0]   beats_q, beats_d;
  logic             done_q, done_d;

  logic [3:0]       wr_en_q, wr_en_d;
  logic [ADR_W-1:0] wr_adr_q, wr_adr_d;
  logic [31:0]      wr_dat_q, wr_dat_d;

  logic enq, deq, beat, hz;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign st_rdy   = !rst && (cnt_q < CNT_FULL);
  assign enq      = st_val && st_rdy && (st_be != '0);
  assign beat     = (state_q == S_RLD) && rld_val;
  // Reload beats own the port in RLD; the queue only drains outside it.
  assign deq      = (state_q != S_RLD) && (cnt_q != '0);

  assign sq_empty = (cnt_q == '0);
  assign rld_busy = (state_q != S_IDLE);
  assign rld_rdy  = !rst && (state_q == S_RLD);
  assign rld_done = done_q;
  assign wr_en    = wr_en_q;
  assign wr_adr   = wr_adr_q;
  assign wr_dat   = wr_dat_q;

  always_comb begin
    sq_vld_d = sq_vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (deq) begin
      sq_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d           = ptr_inc(rd_ptr_q);
    end
    if (enq) begin
      sq_vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d           = ptr_inc(wr_ptr_q);
    end
    if (enq && !deq)      cnt_d = cnt_q + CNT_ONE;
    else if (!enq && deq) cnt_d = cnt_q - CNT_ONE;
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    off_d   = off_q;
    beats_d = beats_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rld_start) begin
          base_d  = {rld_adr[ADR_W-1:OFF_W], {OFF_W{1'b0}}};
          off_d   = rld_adr[OFF_W-1:0];
          beats_d = '0;
          state_d = (cnt_q == '0) ? S_RLD : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_d == '0) state_d = S_RLD;
      end
      S_RLD: begin
        if (rld_val) begin
          off_d   = off_q + OFF_ONE;
          beats_d = beats_q + BEAT_ONE;
          if (beats_d == BEAT_END) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_en_d  = '0;
    wr_adr_d = wr_adr_q;
    wr_dat_d = wr_dat_q;
    if (beat) begin
      wr_en_d  = 4'hF;
      wr_adr_d = {base_q[ADR_W-1:OFF_W], off_q};
      wr_dat_d = rld_dat;
    end else if (deq) begin
      wr_en_d  = sq_be_q[rd_ptr_q];
      wr_adr_d = sq_adr_q[rd_ptr_q];
      wr_dat_d = sq_dat_q[rd_ptr_q];
    end
  end

  always_comb begin
    hz = 1'b0;
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      if (sq_vld_q[i] && (sq_adr_q[i] == rd_adr)) hz = 1'b1;
    end
    if ((wr_en_q != '0) && (wr_adr_q == rd_adr)) hz = 1'b1;
    if (rld_busy && (rd_adr[ADR_W-1:OFF_W] == base_q[ADR_W-1:OFF_W])) hz = 1'b1;
    rd_hazard = !rst && hz;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sq_vld_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      base_q   <= '0;
      off_q    <= '0;
      beats_q  <= '0;
      done_q   <= 1'b0;
      wr_en_q  <= '0;
      wr_adr_q <= '0;
      wr_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      sq_vld_q <= sq_vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      off_q    <= off_d;
      beats_q  <= beats_d;
      done_q   <= done_d;
      wr_en_q  <= wr_en_d;
      wr_adr_q <= wr_adr_d;
      wr_dat_q <= wr_dat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      sq_adr_q[wr_ptr_q] <= st_adr;
      sq_be_q[wr_ptr_q]  <= st_be;
      sq_dat_q[wr_ptr_q] <= st_dat;
    end
  end

endmodule

// File: tb/tb_cache_wr_ctl.sv
// Directed bench for cache_wr_ctl: stores, reload wrap, drain, back-pressure, gaps, reset.
module tb_cache_wr_ctl;

  logic        clk, rst;
  logic        st_val, st_rdy;
  logic [9:0]  st_adr;
  logic [3:0]  st_be;
  logic [31:0] st_dat;
  logic        rld_start, rld_busy, rld_rdy, rld_val, rld_done;
  logic [9:0]  rld_adr;
  logic [31:0] rld_dat;
  logic        sq_empty, rd_hazard;
  logic [9:0]  rd_adr;
  logic [3:0]  wr_en;
  logic [9:0]  wr_adr;
  logic [31:0] wr_dat;

  int vecs = 0;
  int errs = 0;

  cache_wr_ctl #(.ADR_W(10), .LINE_WORDS(4), .SQ_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .st_val(st_val), .st_rdy(st_rdy), .st_adr(st_adr), .st_be(st_be), .st_dat(st_dat),
    .rld_start(rld_start), .rld_adr(rld_adr), .rld_busy(rld_busy), .rld_rdy(rld_rdy),
    .rld_val(rld_val), .rld_dat(rld_dat), .rld_done(rld_done),
    .sq_empty(sq_empty), .rd_adr(rd_adr), .rd_hazard(rd_hazard),
    .wr_en(wr_en), .wr_adr(wr_adr), .wr_dat(wr_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    vecs++; if (st_rdy !== 1'b0) begin errs++; $display("FAIL rst_st_rdy: got %b want 0", st_rdy); end
    vecs++; if (rd_hazard !== 1'b0) begin errs++; $display("FAIL rst_hazard: got %b want 0", rd_hazard); end
    vecs++; if (wr_en !== 4'h0) begin errs++; $display("FAIL rst_wr_en: got %h want 0", wr_en); end
    vecs++; if (wr_adr !== 10'h000) begin errs++; $display("FAIL rst_wr_adr: got %h want 000", wr_adr); end
    vecs++; if (wr_dat !== 32'h0) begin errs++; $display("FAIL rst_wr_dat: got %h want 0", wr_dat); end
    vecs++; if (rld_busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", rld_busy); end
    vecs++; if (rld_rdy !== 1'b0) begin errs++; $display("FAIL rst_rld_rdy: got %b want 0", rld_rdy); end
    vecs++; if (rld_done !== 1'b0) begin errs++; $display("FAIL rst_done: got %b want 0", rld_done); end
    vecs++; if (sq_empty !== 1'b1) begin errs++; $display("FAIL rst_sq_empty: got %b want 1", sq_empty); end
    rst = 1'b0;
    #1;
    vecs++; if (st_rdy !== 1'b1) begin errs++; $display("FAIL rst_release_st_rdy: got %b want 1", st_rdy); end
  endtask

  task automatic test_basic();
    st_val = 1'b1; st_adr = 10'h010; st_be = 4'b0011; st_dat = 32'hAABBCCDD;
    step();
    st_val = 1'b0; rd_adr = 10'h010;
    #1;
    vecs++; if (wr_en !== 4'h0) begin errs++; $display("FAIL basic_t1_wr_en: got %h want 0", wr_en); end
    vecs++; if (rd_hazard !== 1'b1) begin errs++; $display("FAIL basic_t1_hazard: got %b want 1", rd_hazard); end
    step();
    vecs++; if (wr_en !== 4'b0011) begin errs++; $display("FAIL basic_wr_en: got %h want 3", wr_en); end
    vecs++; if (wr_adr !== 10'h010) begin errs++; $display("FAIL basic_wr_adr: got %h want 010", wr_adr); end
    vecs++; if (wr_dat !== 32'hAABBCCDD) begin errs++; $display("FAIL basic_wr_dat: got %h want aabbccdd", wr_dat); end
    vecs++; if (rd_hazard !== 1'b1) begin errs++; $display("FAIL basic_t2_hazard: got %b want 1", rd_hazard); end
    step();
    vecs++; if (wr_en !== 4'h0) begin errs++; $display("FAIL basic_idle_wr_en: got %h want 0", wr_en); end
    vecs++; if (wr_adr !== 10'h010) begin errs++; $display("FAIL basic_hold_adr: got %h want 010", wr_adr); end
    vecs++; if (rd_hazard !== 1'b0) begin errs++; $display("FAIL basic_clear_hazard: got %b want 0", rd_hazard); end
    vecs++; if (sq_empty !== 1'b1) begin errs++; $display("FAIL basic_sq_empty: got %b want 1", sq_empty); end
  endtask

  task automatic test_wrap();
    logic [9:0] ea [4];
    ea[0] = 10'h0A6; ea[1] = 10'h0A7; ea[2] = 10'h0A4; ea[3] = 10'h0A5;
    rld_start = 1'b1; rld_adr = 10'h0A6;
    step();
    rld_start = 1'b0; rd_adr = 10'h0A8;
    #1;
    vecs++; if (rld_busy !== 1'b1) begin errs++; $display("FAIL wrap_busy: got %b want 1", rld_busy); end
    vecs++; if (rld_rdy !== 1'b1) begin errs++; $display("FAIL wrap_rld_rdy: got %b want 1", rld_rdy); end
    vecs++; if (rd_hazard !== 1'b0) begin errs++; $display("FAIL wrap_other_line_hazard: got %b want 0", rd_hazard); end
    rd_adr = 10'h0A4;
    #1;
    vecs++; if (rd_hazard !== 1'b1) begin errs++; $display("FAIL wrap_line_hazard: got %b want 1", rd_hazard); end
    for (int i = 0; i < 4; i++) begin
      rld_val = 1'b1; rld_dat = 32'hD000_0000 + 32'(i);
      step();
      vecs++; if (wr_en !== 4'hF) begin errs++; $display("FAIL wrap_wr_en[%0d]: got %h want f", i, wr_en); end
      vecs++; if (wr_adr !== ea[i]) begin errs++; $display("FAIL wrap_wr_adr[%0d]: got %h want %h", i, wr_adr, ea[i]); end
      vecs++; if (wr_dat !== 32'hD000_0000 + 32'(i)) begin errs++; $display("FAIL wrap_wr_dat[%0d]: got %h want %h", i, wr_dat, 32'hD000_0000 + 32'(i)); end
      vecs++; if (rld_done !== (i == 3)) begin errs++; $display("FAIL wrap_done[%0d]: got %b want %b", i, rld_done, (i == 3)); end
      if (i == 1) begin
        vecs++; if (rd_hazard !== 1'b1) begin errs++; $display("FAIL wrap_busy_hazard: got %b want 1", rd_hazard); end
      end
    end
    rld_val = 1'b0;
    vecs++; if (rld_busy !== 1'b0) begin errs++; $display("FAIL wrap_busy_end: got %b want 0", rld_busy); end
    step();
    vecs++; if (wr_en !== 4'h0) begin errs++; $display("FAIL wrap_after_wr_en: got %h want 0", wr_en); end
    vecs++; if (rld_done !== 1'b0) begin errs++; $display("FAIL wrap_after_done: got %b want 0", rld_done); end
  endtask

  task automatic test_back_pressure();
    rld_start = 1'b1; rld_adr = 10'h100;
    step();
    rld_start = 1'b0;
    st_val = 1'b1; st_be = 4'hF; st_adr = 10'h101; st_dat = 32'h1111_1111;
    #1;
    vecs++; if (st_rdy !== 1'b1) begin errs++; $display("FAIL bp_rdy0: got %b want 1", st_rdy); end
    step();
    st_adr = 10'h102; st_dat = 32'h2222_2222;
    #1;
    vecs++; if (st_rdy !== 1'b1) begin errs++; $display("FAIL bp_rdy1: got %b want 1", st_rdy); end
    step();
    st_adr = 10'h103; st_dat = 32'h3333_3333;
    #1;
    vecs++; if (st_rdy !== 1'b0) begin errs++; $display("FAIL bp_full_rdy: got %b want 0", st_rdy); end
    for (int i = 0; i < 2; i++) begin
      step();
      vecs++; if (wr_en !== 4'h0) begin errs++; $display("FAIL bp_no_drain[%0d]: got %h want 0", i, wr_en); end
      vecs++; if (st_rdy !== 1'b0) begin errs++; $display("FAIL bp_stall_rdy[%0d]: got %b want 0", i, st_rdy); end
    end
    for (int i = 0; i < 4; i++) begin
      rld_val = 1'b1; rld_dat = 32'hC000_0000 + 32'(i);
      step();
      vecs++; if (wr_adr !== 10'h100 + 10'(i)) begin errs++; $display("FAIL bp_beat_adr[%0d]: got %h want %h", i, wr_adr, 10'h100 + 10'(i)); end
      vecs++; if (wr_dat !== 32'hC000_0000 + 32'(i)) begin errs++; $display("FAIL bp_beat_dat[%0d]: got %h want %h", i, wr_dat, 32'hC000_0000 + 32'(i)); end
      vecs++; if (rld_done !== (i == 3)) begin errs++; $display("FAIL bp_done[%0d]: got %b want %b", i, rld_done, (i == 3)); end
      vecs++; if (st_rdy !== 1'b0) begin errs++; $display("FAIL bp_beat_rdy[%0d]: got %b want 0", i, st_rdy); end
    end
    rld_val = 1'b0;
    step();
    vecs++; if (wr_en !== 4'hF || wr_adr !== 10'h101 || wr_dat !== 32'h1111_1111) begin errs++; $display("FAIL bp_st0: got %h/%h/%h want f/101/11111111", wr_en, wr_adr, wr_dat); end
    vecs++; if (st_rdy !== 1'b1) begin errs++; $display("FAIL bp_rdy_reopen: got %b want 1", st_rdy); end
    step();
    st_val = 1'b0;
    vecs++; if (wr_en !== 4'hF || wr_adr !== 10'h102 || wr_dat !== 32'h2222_2222) begin errs++; $display("FAIL bp_st1: got %h/%h/%h want f/102/22222222", wr_en, wr_adr, wr_dat); end
    step();
    vecs++; if (wr_en !== 4'hF || wr_adr !== 10'h103 || wr_dat !== 32'h3333_3333) begin errs++; $display("FAIL bp_st2: got %h/%h/%h want f/103/33333333", wr_en, wr_adr, wr_dat); end
    step();
    vecs++; if (wr_en !== 4'h0) begin errs++; $display("FAIL bp_end_wr_en: got %h want 0", wr_en); end
    vecs++; if (sq_empty !== 1'b1) begin errs++; $display("FAIL bp_end_empty: got %b want 1", sq_empty); end
  endtask

  task automatic test_drain();
    st_val = 1'b1; st_be = 4'hF; st_adr = 10'h030; st_dat = 32'h3030_3030;
    step();
    vecs++; if (sq_empty !== 1'b0) begin errs++; $display("FAIL drain_not_empty: got %b want 0", sq_empty); end
    st_adr = 10'h031; st_dat = 32'h3131_3131;
    rld_start = 1'b1; rld_adr = 10'h200;
    rld_val = 1'b1; rld_dat = 32'hBAD0_BAD0;
    #1;
    vecs++; if (rld_rdy !== 1'b0) begin errs++; $display("FAIL drain_rdy_c2: got %b want 0", rld_rdy); end
    step();
    st_val = 1'b0; rld_start = 1'b0;
    vecs++; if (wr_adr !== 10'h030 || wr_dat !== 32'h3030_3030) begin errs++; $display("FAIL drain_st0: got %h/%h want 030/30303030", wr_adr, wr_dat); end
    vecs++; if (rld_rdy !== 1'b0) begin errs++; $display("FAIL drain_rdy_c3: got %b want 0", rld_rdy); end
    vecs++; if (rld_busy !== 1'b1) begin errs++; $display("FAIL drain_busy: got %b want 1", rld_busy); end
    step();
    vecs++; if (wr_adr !== 10'h031 || wr_dat !== 32'h3131_3131) begin errs++; $display("FAIL drain_st1: got %h/%h want 031/31313131", wr_adr, wr_dat); end
    vecs++; if (rld_rdy !== 1'b1) begin errs++; $display("FAIL drain_rdy_rld: got %b want 1", rld_rdy); end
    vecs++; if (sq_empty !== 1'b1) begin errs++; $display("FAIL drain_empty: got %b want 1", sq_empty); end
    for (int i = 0; i < 4; i++) begin
      rld_dat = 32'hE000_0000 + 32'(i);
      step();
      vecs++; if (wr_en !== 4'hF || wr_adr !== 10'h200 + 10'(i)) begin errs++; $display("FAIL drain_beat_adr[%0d]: got %h/%h want f/%h", i, wr_en, wr_adr, 10'h200 + 10'(i)); end
      vecs++; if (wr_dat !== 32'hE000_0000 + 32'(i)) begin errs++; $display("FAIL drain_beat_dat[%0d]: got %h want %h", i, wr_dat, 32'hE000_0000 + 32'(i)); end
      vecs++; if (rld_done !== (i == 3)) begin errs++; $display("FAIL drain_done[%0d]: got %b want %b", i, rld_done, (i == 3)); end
    end
    rld_val = 1'b0;
    step();
  endtask

  task automatic test_zero_be_gaps();
    logic v [7];
    int k;
    v[0] = 1; v[1] = 0; v[2] = 1; v[3] = 0; v[4] = 0; v[5] = 1; v[6] = 1;
    st_val = 1'b1; st_be = 4'h0; st_adr = 10'h040; st_dat = 32'h4444_4444;
    #1;
    vecs++; if (st_rdy !== 1'b1) begin errs++; $display("FAIL zbe_rdy: got %b want 1", st_rdy); end
    step();
    st_val = 1'b0; rd_adr = 10'h040;
    #1;
    vecs++; if (sq_empty !== 1'b1) begin errs++; $display("FAIL zbe_empty: got %b want 1", sq_empty); end
    vecs++; if (rd_hazard !== 1'b0) begin errs++; $display("FAIL zbe_hazard: got %b want 0", rd_hazard); end
    step();
    vecs++; if (wr_en !== 4'h0) begin errs++; $display("FAIL zbe_wr_en: got %h want 0", wr_en); end
    rld_start = 1'b1; rld_adr = 10'h301;
    step();
    rld_start = 1'b0;
    k = 0;
    for (int c = 0; c < 7; c++) begin
      rld_val = v[c]; rld_dat = 32'hF000_0000 + 32'(k);
      step();
      if (v[c]) begin
        vecs++; if (wr_en !== 4'hF || wr_adr !== (10'h300 | 10'((1 + k) % 4))) begin errs++; $display("FAIL gap_beat_adr[%0d]: got %h/%h want f/%h", c, wr_en, wr_adr, 10'h300 | 10'((1 + k) % 4)); end
        vecs++; if (wr_dat !== 32'hF000_0000 + 32'(k)) begin errs++; $display("FAIL gap_beat_dat[%0d]: got %h want %h", c, wr_dat, 32'hF000_0000 + 32'(k)); end
        vecs++; if (rld_done !== (k == 3)) begin errs++; $display("FAIL gap_done[%0d]: got %b want %b", c, rld_done, (k == 3)); end
        k++;
      end else begin
        vecs++; if (wr_en !== 4'h0) begin errs++; $display("FAIL gap_idle_wr_en[%0d]: got %h want 0", c, wr_en); end
        vecs++; if (rld_done !== 1'b0) begin errs++; $display("FAIL gap_idle_done[%0d]: got %b want 0", c, rld_done); end
      end
    end
    rld_val = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    rld_start = 1'b1; rld_adr = 10'h400;
    step();
    rld_start = 1'b0;
    rld_val = 1'b1; rld_dat = 32'h4000_0000;
    st_val = 1'b1; st_be = 4'hF; st_adr = 10'h050; st_dat = 32'h5050_5050;
    step();
    st_val = 1'b0; rld_dat = 32'h4000_0001;
    vecs++; if (wr_adr !== 10'h400) begin errs++; $display("FAIL rmid_beat0: got %h want 400", wr_adr); end
    step();
    vecs++; if (wr_adr !== 10'h401) begin errs++; $display("FAIL rmid_beat1: got %h want 401", wr_adr); end
    vecs++; if (sq_empty !== 1'b0) begin errs++; $display("FAIL rmid_queued: got %b want 0", sq_empty); end
    rst = 1'b1; rld_dat = 32'hDEAD_BEEF; rd_adr = 10'h401;
    #1;
    vecs++; if (st_rdy !== 1'b0) begin errs++; $display("FAIL rmid_st_rdy: got %b want 0", st_rdy); end
    vecs++; if (rd_hazard !== 1'b0) begin errs++; $display("FAIL rmid_hazard: got %b want 0", rd_hazard); end
    step();
    rst = 1'b0; rld_val = 1'b0;
    vecs++; if (wr_en !== 4'h0) begin errs++; $display("FAIL rmid_wr_en: got %h want 0", wr_en); end
    vecs++; if (wr_adr !== 10'h000) begin errs++; $display("FAIL rmid_wr_adr: got %h want 000", wr_adr); end
    vecs++; if (rld_busy !== 1'b0) begin errs++; $display("FAIL rmid_busy: got %b want 0", rld_busy); end
    vecs++; if (sq_empty !== 1'b1) begin errs++; $display("FAIL rmid_empty: got %b want 1", sq_empty); end
    step();
    vecs++; if (wr_en !== 4'h0) begin errs++; $display("FAIL rmid_quiet_wr_en: got %h want 0", wr_en); end
    rld_start = 1'b1; rld_adr = 10'h402;
    step();
    rld_start = 1'b0;
    vecs++; if (rld_rdy !== 1'b1) begin errs++; $display("FAIL rmid_new_rdy: got %b want 1", rld_rdy); end
    for (int i = 0; i < 4; i++) begin
      rld_val = 1'b1; rld_dat = 32'h6000_0000 + 32'(i);
      step();
      vecs++; if (wr_en !== 4'hF || wr_adr !== (10'h400 | 10'((2 + i) % 4))) begin errs++; $display("FAIL rmid_new_adr[%0d]: got %h/%h want f/%h", i, wr_en, wr_adr, 10'h400 | 10'((2 + i) % 4)); end
      vecs++; if (wr_dat !== 32'h6000_0000 + 32'(i)) begin errs++; $display("FAIL rmid_new_dat[%0d]: got %h want %h", i, wr_dat, 32'h6000_0000 + 32'(i)); end
      vecs++; if (rld_done !== (i == 3)) begin errs++; $display("FAIL rmid_new_done[%0d]: got %b want %b", i, rld_done, (i == 3)); end
    end
    rld_val = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; st_val = 1'b0; st_adr = '0; st_be = '0; st_dat = '0;
    rld_start = 1'b0; rld_adr = '0; rld_val = 1'b0; rld_dat = '0; rd_adr = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_pressure();
    test_drain();
    test_zero_be_gaps();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
